// File: rtl/pcie_pio_pkg.sv
// Shared definitions for the PIO endpoint: TLP format/type codes, header field
// offsets within a 128-bit RX beat, and the RX decoder state encoding.
package pcie_pio_pkg;

   // {fmt, type} codes
   localparam logic [6:0] MRD32 = 7'h00;
   localparam logic [6:0] MRD64 = 7'h20;
   localparam logic [6:0] MWR32 = 7'h40;
   localparam logic [6:0] MWR64 = 7'h60;
   localparam logic [6:0] CPL   = 7'h0A;
   localparam logic [6:0] CPLD  = 7'h4A;

   // Bit offsets within beat 0 (DW0 at [31:0])
   localparam int DW0_FT_LO    = 24;
   localparam int DW0_TC_LO    = 20;
   localparam int DW0_TD       = 15;
   localparam int DW0_EP       = 14;
   localparam int DW0_ATTR_LO  = 12;
   localparam int DW0_LEN_LO   = 0;
   localparam int DW1_RID_LO   = 48;
   localparam int DW1_TAG_LO   = 40;
   localparam int DW1_LBE_LO   = 36;
   localparam int DW1_FBE_LO   = 32;
   localparam int DW2_ADDR_LO  = 66;   // addr[12:2] of a 32-bit address
   localparam int DW3_ADDR_LO  = 98;   // addr[12:2] of the low DW of a 64-bit address
   localparam int DW3_LO       = 96;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR64_DATA,
      ST_WR,
      ST_WAIT_CPL,
      ST_DRAIN
   } rx_state_e;

   typedef struct packed {
      logic [2:0]  tc;
      logic        td;
      logic        ep;
      logic [1:0]  attr;
      logic [9:0]  len;
      logic [15:0] rid;
      logic [7:0]  tag;
      logic [7:0]  be;
      logic [10:0] dw_addr;
   } req_hdr_t;

   function automatic req_hdr_t extract_hdr(input logic [127:0] beat);
      req_hdr_t h;
      h.tc      = beat[DW0_TC_LO +: 3];
      h.td      = beat[DW0_TD];
      h.ep      = beat[DW0_EP];
      h.attr    = beat[DW0_ATTR_LO +: 2];
      h.len     = beat[DW0_LEN_LO +: 10];
      h.rid     = beat[DW1_RID_LO +: 16];
      h.tag     = beat[DW1_TAG_LO +: 8];
      h.be      = {beat[DW1_LBE_LO +: 4], beat[DW1_FBE_LO +: 4]};
      // fmt[0] selects the 4-DW header, whose low address lives in DW3
      h.dw_addr = beat[DW0_FT_LO + 5] ? beat[DW3_ADDR_LO +: 11] : beat[DW2_ADDR_LO +: 11];
      return h;
   endfunction

endpackage

// File: rtl/xilinx_pcie_rx_decoder.sv
// PIO RX decoder: turns single-DW MRd/MWr TLPs into completer requests and
// BAR write strobes; everything else is drained and counted.
module xilinx_pcie_rx_decoder
   import pcie_pio_pkg::*;
#(
   parameter int P_DATA_WIDTH = 128,
   parameter int P_KEEP_WIDTH = P_DATA_WIDTH / 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [P_DATA_WIDTH-1:0] m_axis_rx_tdata,
   input  logic [P_KEEP_WIDTH-1:0] m_axis_rx_tkeep,
   input  logic                    m_axis_rx_tlast,
   input  logic                    m_axis_rx_tvalid,
   output logic                    m_axis_rx_tready,
   output logic                    req_compl,
   output logic                    req_compl_wd,
   input  logic                    compl_done,
   output logic [2:0]              req_tc,
   output logic                    req_td,
   output logic                    req_ep,
   output logic [1:0]              req_attr,
   output logic [9:0]              req_len,
   output logic [15:0]             req_rid,
   output logic [7:0]              req_tag,
   output logic [7:0]              req_be,
   output logic [12:0]             req_addr,
   output logic [10:0]             wr_addr,
   output logic [3:0]              wr_be,
   output logic [31:0]             wr_data,
   output logic                    wr_en,
   input  logic                    wr_busy,
   output logic [7:0]              drop_cnt
);

   rx_state_e  state_q, state_d;
   req_hdr_t   hdr_in, hdr_q;
   logic [6:0] fmt_type;
   logic       len_one;
   logic       lat_hdr, lat_dw3, lat_dw0, compl_set, drop_inc;

   // Header bits beyond addr[12:2] and the byte valids carry nothing we decode
   logic unused_bits;
   assign unused_bits = ^{m_axis_rx_tkeep, m_axis_rx_tdata[95:77], m_axis_rx_tdata[65:64]};

   assign hdr_in   = extract_hdr(m_axis_rx_tdata[127:0]);
   assign fmt_type = m_axis_rx_tdata[DW0_FT_LO +: 7];
   assign len_one  = (hdr_in.len == 10'd1);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d          = state_q;
      m_axis_rx_tready = 1'b0;
      wr_en            = 1'b0;
      lat_hdr          = 1'b0;
      lat_dw3          = 1'b0;
      lat_dw0          = 1'b0;
      compl_set        = 1'b0;
      drop_inc         = 1'b0;
      // Reset is synchronous, so gate the Mealy outputs while it is held
      if (i_rst_n) begin
         unique case (state_q)
            ST_IDLE: begin
               m_axis_rx_tready = 1'b1;
               if (m_axis_rx_tvalid) begin
                  if (len_one && (fmt_type == MRD32 || fmt_type == MRD64)) begin
                     lat_hdr   = 1'b1;
                     compl_set = 1'b1;
                     state_d   = ST_WAIT_CPL;
                  end else if (len_one && fmt_type == MWR32) begin
                     lat_hdr = 1'b1;
                     lat_dw3 = 1'b1;
                     state_d = ST_WR;
                  end else if (len_one && fmt_type == MWR64) begin
                     lat_hdr = 1'b1;
                     state_d = ST_WR64_DATA;
                  end else begin
                     drop_inc = 1'b1;
                     state_d  = m_axis_rx_tlast ? ST_IDLE : ST_DRAIN;
                  end
               end
            end
            ST_WR64_DATA: begin
               m_axis_rx_tready = 1'b1;
               if (m_axis_rx_tvalid) begin
                  if (m_axis_rx_tlast) begin
                     lat_dw0 = 1'b1;
                     state_d = ST_WR;
                  end else begin
                     drop_inc = 1'b1;
                     state_d  = ST_DRAIN;
                  end
               end
            end
            ST_WR: begin
               if (!wr_busy) begin
                  wr_en   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_WAIT_CPL: begin
               if (compl_done) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
               m_axis_rx_tready = 1'b1;
               if (m_axis_rx_tvalid && m_axis_rx_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // NOTE: the datapath registers are reset too, because every output must read 0 in reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         hdr_q        <= '0;
         wr_data      <= '0;
         req_compl    <= 1'b0;
         req_compl_wd <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         if (lat_hdr) hdr_q   <= hdr_in;
         if (lat_dw3) wr_data <= m_axis_rx_tdata[DW3_LO +: 32];
         if (lat_dw0) wr_data <= m_axis_rx_tdata[31:0];
         req_compl    <= compl_set;
         req_compl_wd <= compl_set;
         if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
   end

   assign req_tc   = hdr_q.tc;
   assign req_td   = hdr_q.td;
   assign req_ep   = hdr_q.ep;
   assign req_attr = hdr_q.attr;
   assign req_len  = hdr_q.len;
   assign req_rid  = hdr_q.rid;
   assign req_tag  = hdr_q.tag;
   assign req_be   = hdr_q.be;
   assign req_addr = {hdr_q.dw_addr, 2'b00};
   assign wr_addr  = hdr_q.dw_addr;
   assign wr_be    = hdr_q.be[3:0];

endmodule

// File: tb/tb_xilinx_pcie_rx_decoder.sv
// Scoreboard bench for xilinx_pcie_rx_decoder: directed TLPs push expected
// completion requests / writes; a negedge monitor pops and compares them.
module tb_xilinx_pcie_rx_decoder;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic [127:0] m_axis_rx_tdata;
   logic [15:0]  m_axis_rx_tkeep;
   logic         m_axis_rx_tlast;
   logic         m_axis_rx_tvalid;
   logic         m_axis_rx_tready;
   logic         req_compl, req_compl_wd, compl_done;
   logic [2:0]   req_tc;
   logic         req_td, req_ep;
   logic [1:0]   req_attr;
   logic [9:0]   req_len;
   logic [15:0]  req_rid;
   logic [7:0]   req_tag, req_be;
   logic [12:0]  req_addr;
   logic [10:0]  wr_addr;
   logic [3:0]   wr_be;
   logic [31:0]  wr_data;
   logic         wr_en, wr_busy;
   logic [7:0]   drop_cnt;

   typedef struct {
      logic [2:0]  tc;
      logic        td;
      logic        ep;
      logic [1:0]  attr;
      logic [15:0] rid;
      logic [7:0]  tag;
      logic [7:0]  be;
      logic [12:0] addr;
   } cpl_exp_t;

   typedef struct {
      logic [10:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_exp_t;

   cpl_exp_t cpl_q[$];
   wr_exp_t  wr_q[$];
   int checks = 0;
   int errors = 0;

   xilinx_pcie_rx_decoder dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .m_axis_rx_tdata  (m_axis_rx_tdata),
      .m_axis_rx_tkeep  (m_axis_rx_tkeep),
      .m_axis_rx_tlast  (m_axis_rx_tlast),
      .m_axis_rx_tvalid (m_axis_rx_tvalid),
      .m_axis_rx_tready (m_axis_rx_tready),
      .req_compl        (req_compl),
      .req_compl_wd     (req_compl_wd),
      .compl_done       (compl_done),
      .req_tc           (req_tc),
      .req_td           (req_td),
      .req_ep           (req_ep),
      .req_attr         (req_attr),
      .req_len          (req_len),
      .req_rid          (req_rid),
      .req_tag          (req_tag),
      .req_be           (req_be),
      .req_addr         (req_addr),
      .wr_addr          (wr_addr),
      .wr_be            (wr_be),
      .wr_data          (wr_data),
      .wr_en            (wr_en),
      .wr_busy          (wr_busy),
      .drop_cnt         (drop_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] tlp(input logic [6:0] ft, input logic [2:0] tc,
                                        input logic td, input logic ep, input logic [1:0] attr,
                                        input logic [9:0] len, input logic [15:0] rid,
                                        input logic [7:0] tag, input logic [3:0] lbe,
                                        input logic [3:0] fbe, input logic [31:0] dw2,
                                        input logic [31:0] dw3);
      logic [31:0] dw0, dw1;
      dw0 = {1'b0, ft, 1'b0, tc, 4'b0000, td, ep, attr, 2'b00, len};
      dw1 = {rid, tag, lbe, fbe};
      return {dw3, dw2, dw1, dw0};
   endfunction

   // Presents one beat; returns 1 ns after the edge that accepted it.
   task automatic send_beat(input logic [127:0] d, input logic last);
      int budget = 20;
      m_axis_rx_tdata  = d;
      m_axis_rx_tlast  = last;
      m_axis_rx_tvalid = 1'b1;
      while (!m_axis_rx_tready && budget > 0) begin
         @(posedge i_clk); #1;
         budget--;
      end
      if (!m_axis_rx_tready) check("beat_accept_timeout", 64'd0, 64'd1);
      else begin
         @(posedge i_clk); #1;
      end
      m_axis_rx_tvalid = 1'b0;
      m_axis_rx_tlast  = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge i_clk); #1; end
   endtask

   task automatic pulse_compl_done();
      compl_done = 1'b1;
      cycles(1);
      compl_done = 1'b0;
   endtask

   // Monitor: every strobe must match the oldest expectation
   always @(negedge i_clk) begin
      if (req_compl) begin
         if (cpl_q.size() == 0) check("req_compl_unexpected", 64'd1, 64'd0);
         else begin
            cpl_exp_t e;
            e = cpl_q.pop_front();
            check("cpl_wd",   {63'd0, req_compl_wd}, 64'd1);
            check("cpl_tag",  {56'd0, req_tag}, {56'd0, e.tag});
            check("cpl_rid",  {48'd0, req_rid}, {48'd0, e.rid});
            check("cpl_be",   {56'd0, req_be}, {56'd0, e.be});
            check("cpl_addr", {51'd0, req_addr}, {51'd0, e.addr});
            check("cpl_attrs", {56'd0, req_tc, req_td, req_ep, req_attr},
                               {56'd0, e.tc, e.td, e.ep, e.attr});
            check("cpl_len",  {54'd0, req_len}, 64'd1);
         end
      end
      if (wr_en) begin
         if (wr_q.size() == 0) check("wr_en_unexpected", 64'd1, 64'd0);
         else begin
            wr_exp_t w;
            w = wr_q.pop_front();
            check("wr_addr", {53'd0, wr_addr}, {53'd0, w.addr});
            check("wr_be",   {60'd0, wr_be}, {60'd0, w.be});
            check("wr_data", {32'd0, wr_data}, {32'd0, w.data});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0; compl_done = 1'b0; wr_busy = 1'b0;
      m_axis_rx_tdata = '0; m_axis_rx_tkeep = '1; m_axis_rx_tlast = 1'b0; m_axis_rx_tvalid = 1'b0;
      cycles(3);
      check("rst_outputs", {req_compl, wr_en, drop_cnt, req_tag, wr_data}, 64'd0);
      i_rst_n = 1'b1;
      #1;
      check("tready_after_reset", {63'd0, m_axis_rx_tready}, 64'd1);

      // MRd32, tag 1A, addr 0x104
      cpl_q.push_back('{tc: 3'd2, td: 1'b1, ep: 1'b0, attr: 2'b01, rid: 16'hABCD,
                        tag: 8'h1A, be: 8'h0F, addr: 13'h104});
      send_beat(tlp(7'h00, 3'd2, 1'b1, 1'b0, 2'b01, 10'd1, 16'hABCD, 8'h1A, 4'h0, 4'hF,
                    32'h0000_0104, 32'h0), 1'b1);
      check("mrd_tready_low", {63'd0, m_axis_rx_tready}, 64'd0);
      cycles(3);
      check("mrd_still_waiting", {63'd0, m_axis_rx_tready}, 64'd0);
      check("mrd_tag_stable", {56'd0, req_tag}, 64'h1A);
      pulse_compl_done();
      check("mrd_released", {63'd0, m_axis_rx_tready}, 64'd1);

      // Stray compl_done in IDLE is ignored
      pulse_compl_done();
      check("stray_done_idle", {62'd0, m_axis_rx_tready, req_compl}, 64'd2);

      // compl_done coinciding with req_compl ends the wait
      cpl_q.push_back('{tc: 3'd0, td: 1'b0, ep: 1'b1, attr: 2'b10, rid: 16'h0102,
                        tag: 8'h2B, be: 8'h0C, addr: 13'h0A8});
      send_beat(tlp(7'h00, 3'd0, 1'b0, 1'b1, 2'b10, 10'd1, 16'h0102, 8'h2B, 4'h0, 4'hC,
                    32'hFFFF_00A8, 32'h0), 1'b1);
      check("same_cycle_req_compl", {63'd0, req_compl}, 64'd1);
      pulse_compl_done();
      check("same_cycle_done_idle", {63'd0, m_axis_rx_tready}, 64'd1);

      // MWr32 addr 0x10 data DEADBEEF, wr_en next cycle
      wr_q.push_back('{addr: 11'h004, be: 4'hF, data: 32'hDEAD_BEEF});
      send_beat(tlp(7'h40, 3'd0, 1'b0, 1'b0, 2'b00, 10'd1, 16'h0001, 8'h03, 4'h0, 4'hF,
                    32'h0000_0010, 32'hDEAD_BEEF), 1'b1);
      check("mwr32_latency", {63'd0, wr_en}, 64'd1);
      cycles(1);
      check("mwr32_back_idle", {63'd0, m_axis_rx_tready}, 64'd1);

      // MWr64 over two beats, wr_busy held for 3 cycles
      wr_busy = 1'b1;
      wr_q.push_back('{addr: 11'h082, be: 4'h3, data: 32'hCAFE_F00D});
      send_beat(tlp(7'h60, 3'd0, 1'b0, 1'b0, 2'b00, 10'd1, 16'h0001, 8'h04, 4'h0, 4'h3,
                    32'h0000_0001, 32'h0000_0208), 1'b0);
      send_beat({96'h0, 32'hCAFE_F00D}, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("mwr64_busy_hold", {62'd0, wr_en, m_axis_rx_tready}, 64'd0);
         cycles(1);
      end
      wr_busy = 1'b0;
      #1;
      check("mwr64_wr_en", {63'd0, wr_en}, 64'd1);
      cycles(1);
      check("mwr64_back_idle", {62'd0, wr_en, m_axis_rx_tready}, 64'd1);

      // Discards: MRd len=2, then 3-beat IO read
      send_beat(tlp(7'h00, 3'd0, 1'b0, 1'b0, 2'b00, 10'd2, 16'h0001, 8'h05, 4'hF, 4'hF,
                    32'h0000_0020, 32'h0), 1'b1);
      check("drop_len2_idle", {63'd0, m_axis_rx_tready}, 64'd1);
      send_beat(tlp(7'h02, 3'd0, 1'b0, 1'b0, 2'b00, 10'd1, 16'h0001, 8'h06, 4'h0, 4'hF,
                    32'h0000_0030, 32'h0), 1'b0);
      send_beat({4{32'h1111_1111}}, 1'b0);
      send_beat({4{32'h2222_2222}}, 1'b1);
      cycles(1);
      check("drop_cnt_2", {56'd0, drop_cnt}, 64'd2);
      check("drop_no_cpl_pending", cpl_q.size(), 64'd0);

      // Reset during WAIT_CPL, then a fresh MRd64
      cpl_q.push_back('{tc: 3'd1, td: 1'b0, ep: 1'b0, attr: 2'b00, rid: 16'h0F0F,
                        tag: 8'h55, be: 8'h0F, addr: 13'h040});
      send_beat(tlp(7'h00, 3'd1, 1'b0, 1'b0, 2'b00, 10'd1, 16'h0F0F, 8'h55, 4'h0, 4'hF,
                    32'h0000_0040, 32'h0), 1'b1);
      cycles(2);
      i_rst_n = 1'b0;
      #1;
      check("rst_mid_tready", {63'd0, m_axis_rx_tready}, 64'd0);
      cycles(2);
      check("rst_mid_outputs", {req_compl, wr_en, drop_cnt, req_tag, req_rid}, 64'd0);
      i_rst_n = 1'b1;
      #1;
      check("rst_mid_restart", {63'd0, m_axis_rx_tready}, 64'd1);
      cpl_q.push_back('{tc: 3'd7, td: 1'b1, ep: 1'b0, attr: 2'b11, rid: 16'h1234,
                        tag: 8'h77, be: 8'h0F, addr: 13'h1FFC});
      send_beat(tlp(7'h20, 3'd7, 1'b1, 1'b0, 2'b11, 10'd1, 16'h1234, 8'h77, 4'h0, 4'hF,
                    32'h0000_0001, 32'h0000_1FFC), 1'b1);
      cycles(2);
      pulse_compl_done();
      cycles(3);
      check("final_cpl_queue_empty", cpl_q.size(), 64'd0);
      check("final_wr_queue_empty", wr_q.size(), 64'd0);
      check("final_idle", {56'd0, drop_cnt[6:0], m_axis_rx_tready}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
